mac_operand_sequencer: RTL and testbench
========================================

// Module: mac_operand_sequencer
// PURPOSE
// Upstream feeder for the MAC pipeline in the matrix-multiply datapath.
// Buffers one row of A and one column of B (FP64, length K), then streams them as ordered (TA,TB) pairs.
// Pairs carry first/last markers so the MAC accumulator can frame one dot product per job.
// Flags FP64 NaN/Inf operands (exponent 0x7FF) per job.
// PARAMETERS
// DATA_W  64                   operand width (IEEE-754 double)
// DEPTH   16                   max vector length K per job; also the buffer depth for A and B
// K_W     $clog2(DEPTH+1)      width of the length field
// PORTS
// clk          in   1       clock; all logic on rising edge
// rst_n        in   1       synchronous, active-low reset
// start        in   1       job request; sampled only in IDLE
// cfg_len      in   K_W     vector length K for the job; latched on start
// a_valid      in   1       A-element valid
// a_data       in   DATA_W  A element (FP64)
// a_ready      out  1       A element accepted when a_valid&a_ready
// b_valid      in   1       B-element valid
// b_data       in   DATA_W  B element (FP64)
// b_ready      out  1       B element accepted when b_valid&b_ready
// TA_out       out  DATA_W  operand A to MAC
// TB_out       out  DATA_W  operand B to MAC
// pair_valid   out  1       TA_out/TB_out hold a valid pair
// pair_ready   in   1       MAC accepts the pair when pair_valid&pair_ready
// pair_first   out  1       current pair is index 0
// pair_last    out  1       current pair is index K-1
// busy         out  1       state != IDLE
// done         out  1       1-cycle pulse when the job completes
// err_len      out  1       1-cycle pulse when start is rejected
// special_flag out  1       sticky per job: some accepted operand has exp==0x7FF
// BEHAVIOUR
// Reset (rst_n=0 at edge): state IDLE; all outputs 0; counters 0; buffer contents undefined, not reset.
// FSM IDLE->LOAD->STREAM->DONE->IDLE.
// IDLE: start & 1<=cfg_len<=DEPTH -> latch len, clear special_flag and counters, go LOAD.
//   start & (cfg_len==0 | cfg_len>DEPTH) -> err_len=1 for exactly 1 cycle; stay IDLE.
// LOAD: a_ready=(a_cnt<len) and b_ready=(b_cnt<len), driven independently.
//   On an A handshake, write A[a_cnt] and increment a_cnt. B is handled the same way.
//   A and B handshakes may occur in the same cycle.
//   Once both counts reach len (the last handshake edge), go STREAM.
//   a_ready and b_ready are 0 in the next cycle.
// STREAM: TA_out/TB_out/pair_* are registered.
//   pair_valid=1 from the first STREAM cycle, presenting idx 0.
//   On pair_valid&pair_ready: idx++, and the registers load A[idx+1]/B[idx+1].
//   Throughput is 1 pair per cycle while pair_ready=1.
//   While pair_ready=0: TA_out, TB_out, pair_first and pair_last hold stable; no skip, no duplicate.
//   pair_first=(idx==0); pair_last=(idx==len-1); both are 1 when len==1.
//   Handshake on pair_last -> go DONE; pair_valid=0 next cycle.
// DONE: done=1 for 1 cycle -> IDLE. The next start is accepted the following cycle.
// start outside IDLE is ignored; no err_len.
// special_flag: set on any accepted a_data/b_data with bits[62:52]==11'h7FF.
//   Held through DONE until the next accepted start. Zero and subnormal operands do not set it.
// rst_n=0 mid-job: aborts the job; no done pulse; all outputs 0 next cycle.
// No arithmetic is done here; operand bits pass through unmodified.
// TESTING
// T1 len=3, A={BFFA000000000000,3FF0000000000000,0}, B={4004CCCCCCCCCCCD,4000000000000000,3FF0000000000000}, pair_ready=1
//   -> 3 pairs in order on consecutive cycles, first on pair0, last on pair2.
//   -> done 1 cycle after the pair2 handshake; special_flag=0.
// T2 len=4, all A offered at once, B delayed 5 cycles
//   -> a_ready=0 after 4 A handshakes; STREAM only after the 4th B; pair order intact.
// T3 len=5, pair_ready pattern 1,0,0,1,0,1...
//   -> outputs stable during stalls; exactly 5 handshakes; idx sequence 0..4.
// T4 start with cfg_len=0, then with cfg_len=17
//   -> err_len 1-cycle pulse each time; busy, a_ready and b_ready stay 0.
// T5 len=2, A[1]=7FF8000000000000 -> special_flag=1 from the accept through done.
//   -> next start clears it.
// T6 rst_n=0 during STREAM at idx 1 -> all outputs 0 next edge; no done.
//   -> a fresh len=1 job then completes with pair_first=pair_last=1.

Source files
------------

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer
// Upstream feeder for the MAC pipeline of the matrix-multiply datapath.
// It collects one row of A and one column of B (FP64 elements, K of each),
// then plays them back as ordered (TA,TB) pairs. Each pair is framed with
// first/last markers so the accumulator can delimit one dot product per job.
// Any accepted operand with an all-ones exponent (NaN/Inf) raises a sticky
// per-job flag. Operand bits are passed through untouched.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   start, cfg_len          job request and vector length K (sampled in IDLE)
//   a_valid/a_data/a_ready  A element input stream
//   b_valid/b_data/b_ready  B element input stream
//   TA_out, TB_out          operand pair to the MAC
//   pair_valid/pair_ready   pair handshake
//   pair_first, pair_last   pair is index 0 / index K-1
//   busy                    a job is in progress
//   done                    one-cycle pulse at job completion
//   err_len                 one-cycle pulse when a start carries a bad length
//   special_flag            sticky: some accepted operand is NaN/Inf
module mac_operand_sequencer #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int K_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [K_W-1:0]    cfg_len,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [DATA_W-1:0] TA_out,
  output logic [DATA_W-1:0] TB_out,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic              pair_first,
  output logic              pair_last,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  output logic              special_flag
);

  localparam int A_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, FINISH} state_t;

  state_t state, state_nxt;

  logic [K_W-1:0]    len, a_cnt, b_cnt, idx;
  logic [K_W-1:0]    a_cnt_nxt, b_cnt_nxt, idx_nxt;
  logic [DATA_W-1:0] a_mem [DEPTH];
  logic [DATA_W-1:0] b_mem [DEPTH];
  logic [A_W-1:0]    rd_idx;
  logic [DATA_W-1:0] a_rd, b_rd;
  logic              len_ok, a_hs, b_hs, pair_hs, a_special, b_special;

  assign len_ok    = (cfg_len != '0) && (cfg_len <= K_W'(DEPTH));
  assign a_ready   = (state == LOAD) && (a_cnt < len);
  assign b_ready   = (state == LOAD) && (b_cnt < len);
  assign a_hs      = a_valid && a_ready;
  assign b_hs      = b_valid && b_ready;
  assign pair_hs   = pair_valid && pair_ready;
  assign a_cnt_nxt = a_cnt + (a_hs ? K_W'(1) : K_W'(0));
  assign b_cnt_nxt = b_cnt + (b_hs ? K_W'(1) : K_W'(0));
  assign idx_nxt   = idx + K_W'(1);
  assign a_special = (a_data[DATA_W-2 -: 11] == 11'h7FF);
  assign b_special = (b_data[DATA_W-2 -: 11] == 11'h7FF);

  // The pair registers load element 0 on the same edge that may write it
  // (e.g. K=1), so the write data is forwarded around the buffer.
  assign rd_idx = (state == STREAM) ? idx_nxt[A_W-1:0] : '0;
  assign a_rd   = (a_hs && (a_cnt[A_W-1:0] == rd_idx)) ? a_data : a_mem[rd_idx];
  assign b_rd   = (b_hs && (b_cnt[A_W-1:0] == rd_idx)) ? b_data : b_mem[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && len_ok) state_nxt = LOAD;
      end
      LOAD: begin
        if ((a_cnt_nxt == len) && (b_cnt_nxt == len)) state_nxt = STREAM;
      end
      STREAM: begin
        if (pair_hs && pair_last) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand buffers are plain storage; their contents are meaningless
  // until written during LOAD, so they carry no reset.
  always_ff @(posedge clk) begin
    if (a_hs) a_mem[a_cnt[A_W-1:0]] <= a_data;
    if (b_hs) b_mem[b_cnt[A_W-1:0]] <= b_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len          <= '0;
      a_cnt        <= '0;
      b_cnt        <= '0;
      idx          <= '0;
      TA_out       <= '0;
      TB_out       <= '0;
      pair_valid   <= 1'b0;
      pair_first   <= 1'b0;
      pair_last    <= 1'b0;
      special_flag <= 1'b0;
      err_len      <= 1'b0;
    end else begin
      err_len <= (state == IDLE) && start && !len_ok;
      case (state)
        IDLE: begin
          if (start && len_ok) begin
            len          <= cfg_len;
            a_cnt        <= '0;
            b_cnt        <= '0;
            idx          <= '0;
            special_flag <= 1'b0;
          end
        end
        LOAD: begin
          a_cnt <= a_cnt_nxt;
          b_cnt <= b_cnt_nxt;
          if ((a_hs && a_special) || (b_hs && b_special)) special_flag <= 1'b1;
          if (state_nxt == STREAM) begin
            TA_out     <= a_rd;
            TB_out     <= b_rd;
            pair_valid <= 1'b1;
            pair_first <= 1'b1;
            pair_last  <= (len == K_W'(1));
            idx        <= '0;
          end
        end
        STREAM: begin
          if (pair_hs) begin
            if (pair_last) begin
              pair_valid <= 1'b0;
            end else begin
              idx        <= idx_nxt;
              TA_out     <= a_rd;
              TB_out     <= b_rd;
              pair_first <= 1'b0;
              pair_last  <= (idx_nxt == len - K_W'(1));
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer
// Drives jobs into mac_operand_sequencer and compares every cycle against a
// reference model built from element counts: how many A and B elements have
// been accepted and how many pairs the MAC has taken.
module tb_mac_operand_sequencer;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 16;
  localparam int K_W    = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [K_W-1:0]    cfg_len = '0;
  logic              a_valid = 1'b0;
  logic [DATA_W-1:0] a_data = '0;
  logic              a_ready;
  logic              b_valid = 1'b0;
  logic [DATA_W-1:0] b_data = '0;
  logic              b_ready;
  logic [DATA_W-1:0] TA_out, TB_out;
  logic              pair_valid;
  logic              pair_ready = 1'b0;
  logic              pair_first, pair_last, busy, done, err_len, special_flag;

  mac_operand_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .K_W(K_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .TA_out(TA_out), .TB_out(TB_out),
    .pair_valid(pair_valid), .pair_ready(pair_ready),
    .pair_first(pair_first), .pair_last(pair_last),
    .busy(busy), .done(done), .err_len(err_len), .special_flag(special_flag)
  );

  always #5 clk = ~clk;

  int vecCount = 0;
  int missCount = 0;

  // Reference model state for the current job
  logic [63:0] aVec [DEPTH];
  logic [63:0] bVec [DEPTH];
  int jobLen;
  int ai, bi, pi;
  bit expSpecial;
  int readyPat [6] = '{1, 0, 0, 1, 0, 1};

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %h expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic bit isSpecial(input logic [63:0] v);
    return v[62:52] == 11'h7FF;
  endfunction

  function automatic logic [63:0] genOperand(input bit allowSpecial);
    logic [63:0] v;
    int sel;
    sel = $urandom_range(0, 7);
    v = {$urandom, $urandom};
    case (sel)
      0: v = 64'h0;
      1: v[62:52] = 11'h000;
      2: v[62:52] = 11'h7FF;
      default: ;
    endcase
    if (!allowSpecial && isSpecial(v)) v[62] = 1'b0;
    return v;
  endfunction

  task automatic fillRandom(input int len, input bit allowSpecial);
    for (int i = 0; i < DEPTH; i++) begin
      aVec[i] = genOperand(allowSpecial);
      bVec[i] = genOperand(allowSpecial);
    end
  endtask

  // Drives one cycle of handshake inputs according to the chosen pattern:
  // 0 random, 1 always ready/valid, 2 B held back 5 cycles, 3 fixed stall pattern.
  task automatic applyStimulus(input int mode, input int cyc, input int streamCyc);
    case (mode)
      0: begin
        a_valid    = ($urandom_range(0, 3) != 0);
        b_valid    = ($urandom_range(0, 3) != 0);
        pair_ready = ($urandom_range(0, 3) != 0);
        start      = ($urandom_range(0, 7) == 0);
        cfg_len    = K_W'($urandom_range(0, 20));
      end
      1: begin a_valid = 1'b1; b_valid = 1'b1; pair_ready = 1'b1; start = 1'b0; end
      2: begin a_valid = 1'b1; b_valid = (cyc >= 5); pair_ready = 1'b1; start = 1'b0; end
      default: begin
        a_valid = 1'b1; b_valid = 1'b1; start = 1'b0;
        pair_ready = readyPat[streamCyc % 6][0];
      end
    endcase
    a_data = (ai < jobLen) ? aVec[ai] : {$urandom, $urandom};
    b_data = (bi < jobLen) ? bVec[bi] : {$urandom, $urandom};
  endtask

  task automatic idleInputs();
    start = 1'b0; a_valid = 1'b0; b_valid = 1'b0; pair_ready = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_TA"}, TA_out, 0);
    checkOutput({tag, "_TB"}, TB_out, 0);
    checkOutput({tag, "_pvalid"}, pair_valid, 0);
    checkOutput({tag, "_pfirst"}, pair_first, 0);
    checkOutput({tag, "_plast"}, pair_last, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_err"}, err_len, 0);
    checkOutput({tag, "_aready"}, a_ready, 0);
    checkOutput({tag, "_bready"}, b_ready, 0);
    checkOutput({tag, "_special"}, special_flag, 0);
  endtask

  task automatic runJob(input int len, input int mode, input int abortIdx);
    bit loaded, finished, aborted;
    int streamCyc;
    jobLen = len; ai = 0; bi = 0; pi = 0; expSpecial = 0;
    finished = 0; aborted = 0; streamCyc = 0;
    @(posedge clk); #1;
    idleInputs();
    start = 1'b1; cfg_len = K_W'(len);
    @(negedge clk);
    checkOutput("busy_before_start", busy, 0);
    for (int cyc = 0; cyc < 600 && !finished && !aborted; cyc++) begin
      @(posedge clk); #1;
      loaded = (ai == len) && (bi == len);
      if (abortIdx >= 0 && loaded && pi == abortIdx) begin
        idleInputs();
        rst_n = 1'b0;
        aborted = 1;
      end else begin
        applyStimulus(mode, cyc, streamCyc);
      end
      @(negedge clk);
      checkOutput("busy", busy, 1);
      checkOutput("a_ready", a_ready, (ai < len));
      checkOutput("b_ready", b_ready, (bi < len));
      checkOutput("err_len_busy", err_len, 0);
      checkOutput("special_flag", special_flag, expSpecial);
      if (pi == len) begin
        checkOutput("done", done, 1);
        checkOutput("pair_valid_end", pair_valid, 0);
        finished = 1;
      end else begin
        checkOutput("done_early", done, 0);
        checkOutput("pair_valid", pair_valid, loaded);
        if (loaded) begin
          checkOutput("TA_out", TA_out, aVec[pi]);
          checkOutput("TB_out", TB_out, bVec[pi]);
          checkOutput("pair_first", pair_first, (pi == 0));
          checkOutput("pair_last", pair_last, (pi == len - 1));
        end
      end
      if (a_valid && ai < len) begin
        if (isSpecial(aVec[ai])) expSpecial = 1;
        ai++;
      end
      if (b_valid && bi < len) begin
        if (isSpecial(bVec[bi])) expSpecial = 1;
        bi++;
      end
      if (loaded && !finished && pair_ready) pi++;
      if (loaded) streamCyc++;
    end
    if (aborted) begin
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkAllZero("abort");
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("abort_no_done", done, 0);
      end
    end else begin
      checkOutput("job_finished", finished, 1);
      @(posedge clk); #1;
      idleInputs();
      @(negedge clk);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_done", done, 0);
      checkOutput("special_held", special_flag, expSpecial);
    end
  endtask

  task automatic rejectStart(input int len);
    @(posedge clk); #1;
    idleInputs();
    start = 1'b1; cfg_len = K_W'(len);
    @(negedge clk);
    checkOutput("rej_err_pre", err_len, 0);
    @(posedge clk); #1;
    start = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    @(negedge clk);
    checkOutput("rej_err_pulse", err_len, 1);
    checkOutput("rej_busy", busy, 0);
    checkOutput("rej_aready", a_ready, 0);
    checkOutput("rej_bready", b_ready, 0);
    @(posedge clk); #1;
    idleInputs();
    @(negedge clk);
    checkOutput("rej_err_clear", err_len, 0);
    checkOutput("rej_busy2", busy, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Three-element dot product, no back-pressure
    $display("[TB] directed len=3 job");
    aVec[0] = 64'hBFFA000000000000; aVec[1] = 64'h3FF0000000000000; aVec[2] = 64'h0;
    bVec[0] = 64'h4004CCCCCCCCCCCD; bVec[1] = 64'h4000000000000000; bVec[2] = 64'h3FF0000000000000;
    runJob(3, 1, -1);

    // A arrives immediately, B held back
    $display("[TB] len=4 with delayed B");
    fillRandom(4, 1'b1);
    runJob(4, 2, -1);

    // MAC stalls with a fixed ready pattern
    $display("[TB] len=5 with pair_ready stalls");
    fillRandom(5, 1'b1);
    runJob(5, 3, -1);

    // Illegal lengths
    $display("[TB] rejected starts");
    rejectStart(0);
    rejectStart(17);

    // NaN operand raises the flag, next job clears it
    $display("[TB] special operand flag");
    fillRandom(2, 1'b0);
    aVec[1] = 64'h7FF8000000000000;
    runJob(2, 1, -1);
    fillRandom(2, 1'b0);
    runJob(2, 1, -1);

    // Reset while streaming, then a single-element job
    $display("[TB] reset during stream");
    fillRandom(3, 1'b1);
    runJob(3, 1, 1);
    fillRandom(1, 1'b1);
    runJob(1, 1, -1);

    // Randomized jobs
    $display("[TB] randomized jobs");
    for (int j = 0; j < 30; j++) begin
      if ($urandom_range(0, 5) == 0) rejectStart(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(17, 31)));
      fillRandom(DEPTH, ($urandom_range(0, 1) == 0));
      runJob($urandom_range(1, DEPTH), 0, ($urandom_range(0, 9) == 0) ? 0 : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
